// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/halt control for an in-order pipeline.
// Optional performance counters enabled with `define PIPE_HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int STAGES      = 5,
  parameter int FLUSH_STAGE = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [STAGES-1:0] stall_req,
  input  logic              flush_req,
  input  logic              halt_req,
  input  logic              fetch_valid,
  output logic [STAGES-1:0] en,
  output logic [STAGES-1:0] valid,
  output logic              halted,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] hold;
  logic              flush_acc;

  // A stall anywhere holds that stage and every younger stage behind it.
  always_comb begin
    logic acc;
    acc  = 1'b0;
    hold = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc     = acc | stall_req[i];
      hold[i] = acc;
    end
  end

  always_comb begin
    en = ~hold;
    if (state_q != RUN) en[0] = 1'b0;
  end

  assign flush_acc = flush_req & valid_q[FLUSH_STAGE] & ~hold[FLUSH_STAGE];

  always_comb begin
    valid_d = valid_q;
    if (!hold[0]) valid_d[0] = fetch_valid & (state_q == RUN);
    for (int i = 1; i < STAGES; i++) begin
      if (!hold[i]) valid_d[i] = valid_q[i-1] & ~hold[i-1];
    end
    // Flush kills the wrong-path instructions even in held stages.
    if (flush_acc) begin
      for (int i = 0; i <= FLUSH_STAGE; i++) valid_d[i] = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (halt_req && valid_q[1] && !hold[1] && !flush_acc) state_d = DRAIN;
      end
      DRAIN: begin
        if (valid_q[STAGES-1:2] == '0) state_d = HALTED;
      end
      HALTED: state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  assign valid  = valid_q;
  assign halted = (state_q == HALTED);

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (hold[0] && state_q != HALTED && stall_cycles_q != 32'hFFFF_FFFF)
      stall_cycles_d = stall_cycles_q + 32'd1;
    if (flush_acc && flush_count_q != 32'hFFFF_FFFF)
      flush_count_d = flush_count_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and random checks of pipe_hazard_ctrl against a reference model.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  stall;
  logic        flush;
  logic        halt;
  logic        fetch;
  logic [4:0]  en;
  logic [4:0]  valid;
  logic        halted;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  int checks = 0;
  int errors = 0;

  // Reference model state: 0 = running, 1 = draining, 2 = halted.
  logic [4:0]  m_valid = '0;
  int          m_state = 0;
  logic [31:0] m_sc = '0;
  logic [31:0] m_fc = '0;

  pipe_hazard_ctrl #(.STAGES(5), .FLUSH_STAGE(2)) dut (
    .clock        (clk),
    .reset        (rst),
    .stall_req    (stall),
    .flush_req    (flush),
    .halt_req     (halt),
    .fetch_valid  (fetch),
    .en           (en),
    .valid        (valid),
    .halted       (halted),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check en before the edge, advance the model, check state after the edge.
  task automatic cycle();
    int         oldest;
    logic [4:0] en_e;
    logic [4:0] nv;
    logic       fok;
    #1;
    oldest = -1;
    for (int j = 0; j < 5; j++) if (stall[j]) oldest = j;
    for (int i = 0; i < 5; i++) en_e[i] = (i > oldest);
    if (m_state != 0) en_e[0] = 1'b0;
    chk("en", en, en_e);

    if (rst) begin
      nv = '0; m_state = 0; m_sc = '0; m_fc = '0;
    end else begin
      fok = flush && m_valid[2] && (oldest < 2);
      if (oldest < 0) begin
        nv = {m_valid[3:0], fetch && (m_state == 0)};
      end else begin
        nv = m_valid;
        for (int i = oldest + 1; i < 5; i++) nv[i] = (i == oldest + 1) ? 1'b0 : m_valid[i-1];
      end
      if (fok) nv[2:0] = 3'b000;
`ifdef PIPE_HAZARD_PERF_CNT_EN
      if (oldest >= 0 && m_state != 2 && m_sc != 32'hFFFF_FFFF) m_sc++;
      if (fok && m_fc != 32'hFFFF_FFFF) m_fc++;
`endif
      if (m_state == 0 && halt && m_valid[1] && oldest < 1 && !fok) m_state = 1;
      else if (m_state == 1 && m_valid[4:2] == 3'b000) m_state = 2;
    end
    m_valid = nv;

    @(posedge clk);
    #1;
    chk("valid", valid, m_valid);
    chk("halted", halted, m_state == 2);
    chk("stall_cycles", stall_cycles, m_sc);
    chk("flush_count", flush_count, m_fc);
  endtask

  task automatic idle();
    rst = 1'b0; stall = '0; flush = 1'b0; halt = 1'b0; fetch = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic fill();
    fetch = 1'b1;
    repeat (5) cycle();
    fetch = 1'b0;
  endtask

  initial begin
    logic [4:0] tbl [6];
    tbl[0] = 5'b00001; tbl[1] = 5'b00011; tbl[2] = 5'b00111;
    tbl[3] = 5'b01111; tbl[4] = 5'b11111; tbl[5] = 5'b11111;

    idle();
    @(posedge clk);
    #1;
    do_reset();
    chk("reset_valid", valid, 5'b00000);
    chk("reset_halted", halted, 1'b0);

    fetch = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("fill_seq", valid, tbl[k]);
    end

    stall = 5'b01000;
    #1;
    chk("stall_en", en, 5'b10000);
    repeat (3) cycle();
    chk("stall_valid", valid, 5'b01111);
`ifdef PIPE_HAZARD_PERF_CNT_EN
    chk("stall_cnt", stall_cycles, 32'd3);
`else
    chk("stall_cnt", stall_cycles, 32'd0);
`endif
    stall = '0;

    do_reset();
    fill();
    flush = 1'b1;
    cycle();
    chk("flush_valid", valid, 5'b11000);
`ifdef PIPE_HAZARD_PERF_CNT_EN
    chk("flush_cnt", flush_count, 32'd1);
`else
    chk("flush_cnt", flush_count, 32'd0);
`endif

    do_reset();
    fill();
    halt = 1'b1; flush = 1'b1;
    cycle();
    chk("halt_flush_valid", valid, 5'b11000);
    idle();
    #1;
    chk("halt_flush_run", en, 5'b11111);

    do_reset();
    fetch = 1'b1; cycle();
    fetch = 1'b0; cycle();
    chk("halt_pre_valid", valid, 5'b00010);
    halt = 1'b1; cycle();
    chk("drain_valid", valid, 5'b00100);
    halt = 1'b0; fetch = 1'b1;
    #1;
    chk("drain_en", en, 5'b11110);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("drain_halted", halted, k == 3);
      chk("drain_v0", valid[0], 1'b0);
    end
    repeat (2) cycle();
    chk("halted_hold", valid, 5'b00000);

    do_reset();
    fetch = 1'b1; cycle();
    fetch = 1'b0; cycle();
    halt = 1'b1; cycle();
    halt = 1'b0; fetch = 1'b1; cycle();
    rst = 1'b1; cycle();
    rst = 1'b0; fetch = 1'b0;
    chk("rst_drain_valid", valid, 5'b00000);
    chk("rst_drain_halted", halted, 1'b0);
    chk("rst_drain_sc", stall_cycles, 32'd0);
    chk("rst_drain_fc", flush_count, 32'd0);
    #1;
    chk("rst_drain_en", en, 5'b11111);

    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom % 60) == 0;
      stall = '0;
      for (int i = 0; i < 5; i++) if (($urandom % 10) == 0) stall[i] = 1'b1;
      flush = ($urandom % 6) == 0;
      halt  = ($urandom % 25) == 0;
      fetch = ($urandom % 4) != 0;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
